ram_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the data port of the byte-lane RAM. It accepts byte/half/word load and store requests from the core LSU (requester 0) and the program loader (requester 1), then grants them round-robin. Each granted request is sequenced as one RAM access: byte-enable generation for stores, lane extraction and sign/zero extension for loads. The instruction-fetch read port of the RAM is not touched by this block.

---
 rtl/ram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and access sequencer for the byte-lane RAM data port.
// Two requesters, one outstanding access, lane steering and load extension.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 31,
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [1:0]            m_req_valid,
    output logic [1:0]            m_req_ready,
    input  logic [1:0]            m_req_we,
    input  logic [ADDR_WIDTH:0]   m_req_addr0,
    input  logic [ADDR_WIDTH:0]   m_req_addr1,
    input  logic [1:0]            m_req_size0,
    input  logic [1:0]            m_req_size1,
    input  logic [1:0]            m_req_unsigned,
    input  logic [DATA_WIDTH:0]   m_req_wdata0,
    input  logic [DATA_WIDTH:0]   m_req_wdata1,
    output logic [1:0]            m_resp_valid,
    output logic                  m_resp_err,
    output logic [DATA_WIDTH:0]   m_resp_rdata,
    output logic                  ram_clk_en,
    output logic                  ram_read_req,
    output logic [ADDR_WIDTH:0]   ram_read_addr,
    input  logic [DATA_WIDTH:0]   ram_read_data,
    output logic                  ram_write_enable,
    output logic [3:0]            ram_byte_enable,
    output logic [ADDR_WIDTH:0]   ram_write_addr,
    output logic [DATA_WIDTH:0]   ram_write_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                last_grant_q;
    logic                owner_q;
    logic                we_q;
    logic                uns_q;
    logic                err_q;
    logic [1:0]          size_q;
    logic [ADDR_WIDTH:0] addr_q;
    logic [DATA_WIDTH:0] wdata_q;

    logic                gnt;
    logic                hs;
    logic [ADDR_WIDTH:0] addr_in;
    logic [1:0]          size_in;
    logic [DATA_WIDTH:0] wdata_in;
    logic                illegal_in;
    logic [1:0]          off;
    logic [ADDR_WIDTH:0] word_addr;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] load_ext;
    logic                in_access;
    logic                in_resp;

    assign ram_clk_en = clk_en;

    always_comb begin
        // Both valid: the one not granted last time; otherwise the lone requester
        gnt        = (&m_req_valid) ? ~last_grant_q : m_req_valid[1];
        addr_in    = gnt ? m_req_addr1  : m_req_addr0;
        size_in    = gnt ? m_req_size1  : m_req_size0;
        wdata_in   = gnt ? m_req_wdata1 : m_req_wdata0;
        illegal_in = (size_in == 2'd3)
                   || (size_in == 2'd1 && addr_in[0])
                   || (size_in == 2'd2 && addr_in[1:0] != 2'b00);
        m_req_ready = 2'b00;
        if (state_q == S_IDLE && clk_en && !rst && |m_req_valid)
            m_req_ready = gnt ? 2'b10 : 2'b01;
        hs = |m_req_ready;
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (hs) state_d = illegal_in ? S_RESP : S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            if (hs) begin
                last_grant_q <= gnt;
                owner_q      <= gnt;
                we_q         <= m_req_we[gnt];
                uns_q        <= m_req_unsigned[gnt];
                err_q        <= illegal_in;
                size_q       <= size_in;
                addr_q       <= addr_in;
                wdata_q      <= wdata_in;
            end
        end
    end

    always_comb begin
        off       = addr_q[1:0];
        word_addr = {2'b00, addr_q[ADDR_WIDTH:2]};
        in_access = (state_q == S_ACCESS) && !rst;
        in_resp   = (state_q == S_RESP) && !rst;
        shifted   = ram_read_data >> {off, 3'b000};
        case (size_q)
            2'd0:    load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = ram_read_data;
        endcase

        ram_write_enable = in_access && we_q;
        ram_byte_enable  = 4'b0000;
        ram_write_addr   = '0;
        ram_write_data   = '0;
        if (ram_write_enable) begin
            ram_write_addr = word_addr;
            case (size_q)
                2'd0: begin
                    ram_byte_enable = 4'b0001 << off;
                    ram_write_data  = {4{wdata_q[7:0]}};
                end
                2'd1: begin
                    ram_byte_enable = 4'b0011 << off;
                    ram_write_data  = {2{wdata_q[15:0]}};
                end
                default: begin
                    ram_byte_enable = 4'b1111;
                    ram_write_data  = wdata_q;
                end
            endcase
        end

        // Read address stays up through RESP so the RAM output holds
        ram_read_req  = in_access && !we_q;
        ram_read_addr = '0;
        if ((in_access || in_resp) && !we_q && !err_q)
            ram_read_addr = word_addr;

        m_resp_valid = 2'b00;
        m_resp_err   = 1'b0;
        m_resp_rdata = '0;
        if (in_resp) begin
            m_resp_valid = owner_q ? 2'b10 : 2'b01;
            m_resp_err   = err_q;
            if (!we_q && !err_q)
                m_resp_rdata = load_ext;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small byte-lane RAM model.
// Immediate assertions at each check point; one summary line at the end.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [1:0]  m_req_valid;
    logic [1:0]  m_req_ready;
    logic [1:0]  m_req_we;
    logic [31:0] m_req_addr0, m_req_addr1;
    logic [1:0]  m_req_size0, m_req_size1;
    logic [1:0]  m_req_unsigned;
    logic [31:0] m_req_wdata0, m_req_wdata1;
    logic [1:0]  m_resp_valid;
    logic        m_resp_err;
    logic [31:0] m_resp_rdata;
    logic        ram_clk_en;
    logic        ram_read_req;
    logic [31:0] ram_read_addr;
    logic [31:0] ram_read_data = 32'h0;
    logic        ram_write_enable;
    logic [3:0]  ram_byte_enable;
    logic [31:0] ram_write_addr;
    logic [31:0] ram_write_data;

    logic [31:0] mem [16] = '{default: 32'h0};
    int          nwr = 0;
    int          n_eval = 0;
    int          n_fail = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_we(m_req_we),
        .m_req_addr0(m_req_addr0), .m_req_addr1(m_req_addr1),
        .m_req_size0(m_req_size0), .m_req_size1(m_req_size1),
        .m_req_unsigned(m_req_unsigned),
        .m_req_wdata0(m_req_wdata0), .m_req_wdata1(m_req_wdata1),
        .m_resp_valid(m_resp_valid), .m_resp_err(m_resp_err),
        .m_resp_rdata(m_resp_rdata),
        .ram_clk_en(ram_clk_en), .ram_read_req(ram_read_req),
        .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
        .ram_write_enable(ram_write_enable),
        .ram_byte_enable(ram_byte_enable),
        .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data)
    );

    always #5 clk = ~clk;

    // Byte-lane RAM: registered read, masked write, both gated by ram_clk_en
    always @(posedge clk) begin
        if (ram_clk_en) begin
            if (ram_write_enable) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byte_enable[b])
                        mem[ram_write_addr[3:0]][8*b +: 8] <= ram_write_data[8*b +: 8];
                nwr <= nwr + 1;
            end
            if (ram_read_req)
                ram_read_data <= mem[ram_read_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wd);
        m_req_we[r]       = we;
        m_req_unsigned[r] = uns;
        if (r == 0) begin
            m_req_addr0 = addr; m_req_size0 = size; m_req_wdata0 = wd;
        end else begin
            m_req_addr1 = addr; m_req_size1 = size; m_req_wdata1 = wd;
        end
    endtask

    task automatic do_req(input string tag, input int r, input logic we,
                          input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input logic eerr);
        logic [1:0] oh;
        oh = (r == 1) ? 2'b10 : 2'b01;
        set_req(r, we, addr, size, uns, wd);
        m_req_valid[r] = 1'b1;
        #1;
        chk({tag, "_ready"}, {30'd0, m_req_ready}, {30'd0, oh});
        tick();
        m_req_valid[r] = 1'b0;
        #1;
        if (!eerr) begin
            if (we) begin
                chk({tag, "_wen"}, {31'd0, ram_write_enable}, 32'd1);
                chk({tag, "_be"}, {28'd0, ram_byte_enable}, {28'd0, ebe});
                chk({tag, "_waddr"}, ram_write_addr, addr >> 2);
                chk({tag, "_wdata"}, ram_write_data, ewd);
            end else begin
                chk({tag, "_rreq"}, {31'd0, ram_read_req}, 32'd1);
                chk({tag, "_raddr"}, ram_read_addr, addr >> 2);
            end
            chk({tag, "_noresp"}, {30'd0, m_resp_valid}, 32'd0);
            tick();
        end
        chk({tag, "_rvalid"}, {30'd0, m_resp_valid}, {30'd0, oh});
        chk({tag, "_err"}, {31'd0, m_resp_err}, {31'd0, eerr});
        chk({tag, "_rdata"}, m_resp_rdata, erd);
        chk({tag, "_strobes"}, {30'd0, ram_write_enable, ram_read_req}, 32'd0);
        tick();
    endtask

    initial begin
        int w0;
        rst = 1'b1; clk_en = 1'b1;
        m_req_valid = 2'b00; m_req_we = 2'b00; m_req_unsigned = 2'b00;
        m_req_addr0 = 0; m_req_addr1 = 0; m_req_size0 = 0; m_req_size1 = 0;
        m_req_wdata0 = 0; m_req_wdata1 = 0;
        tick(); tick();
        chk("rst_resp", {30'd0, m_resp_valid}, 32'd0);
        chk("rst_wen", {31'd0, ram_write_enable}, 32'd0);
        chk("rst_clken", {31'd0, ram_clk_en}, 32'd1);
        rst = 1'b0;
        tick();

        do_req("st_word", 0, 1, 32'h10, 2, 0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        do_req("ld_word", 0, 0, 32'h10, 2, 0, 32'h0, 4'b0, 32'h0, 32'hDEADBEEF, 0);
        do_req("st_byte", 0, 1, 32'h13, 0, 0, 32'h00000080, 4'b1000, 32'h80808080, 32'h0, 0);
        do_req("ld_bs", 0, 0, 32'h13, 0, 0, 32'h0, 4'b0, 32'h0, 32'hFFFFFF80, 0);
        do_req("ld_bu", 0, 0, 32'h13, 0, 1, 32'h0, 4'b0, 32'h0, 32'h00000080, 0);
        do_req("st_w1", 1, 1, 32'h10, 2, 0, 32'h80001234, 4'b1111, 32'h80001234, 32'h0, 0);
        do_req("ld_hs", 1, 0, 32'h12, 1, 0, 32'h0, 4'b0, 32'h0, 32'hFFFF8000, 0);
        do_req("ld_hu", 1, 0, 32'h10, 1, 1, 32'h0, 4'b0, 32'h0, 32'h00001234, 0);

        // Contention: both valid, grants alternate starting with requester 0
        set_req(0, 0, 32'h10, 2, 0, 0);
        set_req(1, 0, 32'h12, 1, 0, 0);
        m_req_valid = 2'b11;
        for (int k = 0; k < 12; k++) begin
            logic [1:0] er;
            logic [1:0] ev;
            er = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2) ? 2'b10 : 2'b01);
            ev = (k % 3 != 2) ? 2'b00 : (((k / 3) % 2) ? 2'b10 : 2'b01);
            #1;
            chk($sformatf("rr_ready%0d", k), {30'd0, m_req_ready}, {30'd0, er});
            chk($sformatf("rr_resp%0d", k), {30'd0, m_resp_valid}, {30'd0, ev});
            if (ev == 2'b01) chk($sformatf("rr_rd%0d", k), m_resp_rdata, 32'h80001234);
            if (ev == 2'b10) chk($sformatf("rr_rd%0d", k), m_resp_rdata, 32'hFFFF8000);
            if (k == 11) m_req_valid = 2'b00;
            tick();
        end

        w0 = nwr;
        do_req("ill_half", 0, 0, 32'h01, 1, 0, 32'h0, 4'b0, 32'h0, 32'h0, 1);
        do_req("ill_word", 1, 1, 32'h02, 2, 0, 32'h12345678, 4'b0, 32'h0, 32'h0, 1);
        chk("ill_nowrite", nwr, w0);

        // clk_en stall during a store ACCESS
        w0 = nwr;
        set_req(0, 1, 32'h20, 2, 0, 32'h11223344);
        m_req_valid[0] = 1'b1;
        #1;
        chk("stall_ready", {30'd0, m_req_ready}, 32'd1);
        tick();
        m_req_valid[0] = 1'b0;
        clk_en = 1'b0;
        #1;
        chk("stall_wen0", {31'd0, ram_write_enable}, 32'd1);
        chk("stall_ramclk", {31'd0, ram_clk_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_wen%0d", i + 1), {31'd0, ram_write_enable}, 32'd1);
            chk($sformatf("stall_resp%0d", i + 1), {30'd0, m_resp_valid}, 32'd0);
        end
        tick();
        clk_en = 1'b1;
        #1;
        chk("stall_wen4", {31'd0, ram_write_enable}, 32'd1);
        chk("stall_resp4", {30'd0, m_resp_valid}, 32'd0);
        tick();
        chk("stall_resp", {30'd0, m_resp_valid}, 32'd1);
        chk("stall_nwr", nwr, w0 + 1);
        tick();
        do_req("stall_ld", 0, 0, 32'h20, 2, 0, 32'h0, 4'b0, 32'h0, 32'h11223344, 0);

        // Reset while a store is in ACCESS
        w0 = nwr;
        set_req(0, 1, 32'h24, 0, 0, 32'h000000AA);
        m_req_valid[0] = 1'b1;
        #1;
        chk("rmo_ready", {30'd0, m_req_ready}, 32'd1);
        tick();
        m_req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("rmo_wen", {31'd0, ram_write_enable}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rmo_outs", {m_resp_valid, m_resp_err, ram_read_req, ram_write_enable,
                         ram_byte_enable, m_req_ready, 20'd0}, 32'd0);
        chk("rmo_buses", ram_write_addr | ram_write_data | ram_read_addr | m_resp_rdata, 32'd0);
        tick();
        chk("rmo_noresp", {30'd0, m_resp_valid}, 32'd0);
        chk("rmo_nwr", nwr, w0);
        set_req(0, 0, 32'h24, 2, 0, 0);
        set_req(1, 0, 32'h10, 2, 0, 0);
        m_req_valid = 2'b11;
        #1;
        chk("rmo_grant", {30'd0, m_req_ready}, 32'd1);
        tick();
        m_req_valid = 2'b00;
        tick();
        chk("rmo_resp", {30'd0, m_resp_valid}, 32'd1);
        chk("rmo_rdata", m_resp_rdata, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
